aes_key_expander: RTL



---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sub_word.sv | 17 +
 rtl/aes_key_expander.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, round constants,
// S-box table and the GF(2^8) xtime helper used by MixColumns as well.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam logic [7:0]  AES_RCON_INIT  = 8'h01;
  localparam logic [7:0]  AES_POLY       = 8'h1B;

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Single-byte S-box lookup
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return AES_SBOX[(32'd255 - 32'(b)) * 32'd8 +: 8];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word_c
);

  // Byte-wise substitution
  always_comb begin
    o_word_c = '0;
    for (int i = 0; i < 4; i++) begin
      o_word_c[8*i +: 8] = sbox(i_word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: loads a cipher key and streams round keys 0..10
// over valid/ready, one word-step per accepted key.
// Optional build macro AES_KEYEXP_STORE_EN adds an 11-entry round-key store
// with a combinational read port (rd_idx / rd_key) for reverse-order access.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] key_in,
  input  logic         key_load,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key
`endif
);

  aes_state_e   r_state, w_state_nxt;
  logic [0:127] r_rk, w_rk_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [7:0]   r_rcon, w_rcon_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_busy, r_done;

  logic         w_hs, w_last;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [0:127] w_next_key;

  assign w_hs   = r_valid && rk_ready;
  assign w_last = (r_round == 4'(NUM_ROUNDS));

  assign w_w0  = r_rk[0:31];
  assign w_w1  = r_rk[32:63];
  assign w_w2  = r_rk[64:95];
  assign w_w3  = r_rk[96:127];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  aes_sub_word u_sub_word (
    .i_word   (w_rot),
    .o_word_c (w_sub)
  );

  assign w_t        = w_sub ^ {r_rcon, 24'h0};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // Next state and next register values; key_load overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_round_nxt = r_round;
    w_rcon_nxt  = r_rcon;
    w_valid_nxt = r_valid;
    if (key_load) begin
      w_state_nxt = RUN;
      w_rk_nxt    = key_in;
      w_round_nxt = 4'd0;
      w_rcon_nxt  = AES_RCON_INIT;
      w_valid_nxt = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hs) begin
            if (w_last) begin
              w_state_nxt = DONE;
              w_valid_nxt = 1'b0;
            end else begin
              w_rk_nxt    = w_next_key;
              w_round_nxt = 4'(r_round + 4'd1);
              w_rcon_nxt  = xtime(r_rcon);
            end
          end
        end
        IDLE, DONE: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk    <= '0;
      r_round <= 4'd0;
      r_rcon  <= AES_RCON_INIT;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rk    <= w_rk_nxt;
      r_round <= w_round_nxt;
      r_rcon  <= w_rcon_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign rk_out   = r_rk;
  assign rk_round = r_round;
  assign rk_valid = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;

`ifdef AES_KEYEXP_STORE_EN
  logic [0:127] r_store [0:10];
  logic [10:0]  r_store_vld;
  logic         w_wr_en;
  logic [3:0]   w_wr_idx;

  // A store write happens whenever a new key lands in the output register
  assign w_wr_en  = key_load || ((r_state == RUN) && w_hs && !w_last);
  assign w_wr_idx = key_load ? 4'd0 : 4'(r_round + 4'd1);

  // Entry-valid flags, cleared by each new load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_store_vld <= '0;
    else if (key_load) r_store_vld <= 11'd1;
    else if (w_wr_en)  r_store_vld[w_wr_idx] <= 1'b1;
  end

  // Key storage, qualified by the valid flags on read
  always_ff @(posedge clk) begin
    if (w_wr_en) r_store[w_wr_idx] <= w_rk_nxt;
  end

  // Combinational read, zero for out-of-range or unwritten entries
  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) begin
      if (r_store_vld[rd_idx]) rd_key = r_store[rd_idx];
    end
  end
`endif

endmodule
